// File: rtl/rotation_position_tracker_pkg.sv
// Shared types for the rotation position tracker: re-arm FSM states and step directions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rot_pkg;

    // Re-arm filter states: wait for MIN_LOW lows, armed for a rising event, hold while high.
    typedef enum logic [1:0] {
        REARM = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } rot_state_t;

    localparam logic ROT_INC = 1'b1;
    localparam logic ROT_DEC = 1'b0;

endpackage

// File: rtl/rotation_position_tracker_if.sv
// Bundles the event-detector inputs and the position/LED/step outputs of the tracker.
// Latency: n/a (wiring only).
// Backpressure: none; the event stream is accepted or filtered, never stalled.
// Ports: rotation_event, rotation_direction, clear (master -> slave);
//        position, led, step_pulse, step_dir, limit_hit (slave -> master).
interface rotation_position_tracker_if #(
    parameter int N_POS = 8
);
    localparam int POS_W = $clog2(N_POS);

    logic             rotation_event;
    logic             rotation_direction;
    logic             clear;
    logic [POS_W-1:0] position;
    logic [N_POS-1:0] led;
    logic             step_pulse;
    logic             step_dir;
    logic             limit_hit;

    modport master (
        output rotation_event, rotation_direction, clear,
        input  position, led, step_pulse, step_dir, limit_hit
    );

    modport slave (
        input  rotation_event, rotation_direction, clear,
        output position, led, step_pulse, step_dir, limit_hit
    );
endinterface

// File: rtl/rotation_position_tracker_rearm_filter.sv
// Re-arm filter: turns each qualified rising edge of rotation_event into a one-cycle step_req.
// Latency: step_req is combinational from the ARMED state and the current event sample.
// Backpressure: none; events arriving before MIN_LOW consecutive lows are dropped.
// Ports: clk, rst (async, active-high), rotation_event in, step_req out.
module rot_rearm_filter
    import rot_pkg::*;
#(
    parameter int MIN_LOW = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rotation_event,
    output logic step_req
);
    localparam int CNT_W = $clog2(MIN_LOW + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_LOW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rot_state_t       state_q, state_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;

    always_comb begin
        state_d   = state_q;
        low_cnt_d = low_cnt_q;
        step_req  = 1'b0;
        case (state_q)
            REARM: begin
                if (rotation_event) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q == CNT_LAST) begin
                    // This sample is the MIN_LOW-th consecutive low.
                    state_d   = ARMED;
                    low_cnt_d = '0;
                end else begin
                    low_cnt_d = low_cnt_q + CNT_ONE;
                end
            end
            ARMED: begin
                if (rotation_event) begin
                    step_req = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                // The low that ends HOLD already counts as the first re-arm low.
                if (!rotation_event) begin
                    if (MIN_LOW == 1) begin
                        state_d   = ARMED;
                        low_cnt_d = '0;
                    end else begin
                        state_d   = REARM;
                        low_cnt_d = CNT_ONE;
                    end
                end
            end
            default: begin
                state_d   = REARM;
                low_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= REARM;
            low_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            low_cnt_q <= low_cnt_d;
        end
    end
endmodule

// File: rtl/rotation_position_tracker.sv
// Rotation position tracker: steps a position register on qualified events and drives a one-hot LED vector.
// Latency: position/led/step_pulse/step_dir update on the edge the armed event is sampled high.
// Backpressure: none; re-triggers inside the re-arm window are dropped, not queued.
// Ports: clk, rst (async, active-high), bus (rotation_position_tracker_if.slave).
// Build option ROT_SATURATE_EN: clamp at 0 / N_POS-1 and pulse limit_hit instead of wrapping.
module rotation_position_tracker
    import rot_pkg::*;
#(
    parameter int N_POS    = 8,
    parameter int MIN_LOW  = 4,
    parameter int INIT_POS = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    rotation_position_tracker_if.slave   bus
);
    localparam int POS_W = $clog2(N_POS);
    localparam logic [POS_W-1:0] POS_INIT = POS_W'(INIT_POS);
    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(N_POS - 1);
    localparam logic [POS_W:0]   N_EXT    = (POS_W + 1)'(N_POS);
    localparam logic [POS_W:0]   EXT_ONE  = (POS_W + 1)'(1);
    localparam logic [N_POS-1:0] LED_ONE  = N_POS'(1);

    logic             step_req;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [N_POS-1:0] led_q, led_d;
    logic             step_pulse_q, step_pulse_d;
    logic             step_dir_q, step_dir_d;
    logic [POS_W:0]   ext_inc, ext_dec;
    logic [POS_W-1:0] pos_nxt;

    rot_rearm_filter #(.MIN_LOW(MIN_LOW)) u_filter (
        .clk            (clk),
        .rst            (rst),
        .rotation_event (bus.rotation_event),
        .step_req       (step_req)
    );

    // One extra bit exposes both overflow past N_POS-1 and underflow below 0,
    // so the wrap is correct for non-power-of-2 N_POS.
    assign ext_inc = {1'b0, pos_q} + EXT_ONE;
    assign ext_dec = {1'b0, pos_q} - EXT_ONE;

    always_comb begin
        pos_nxt = pos_q;
        case (bus.rotation_direction)
            ROT_INC: pos_nxt = (ext_inc == N_EXT) ? '0 : ext_inc[POS_W-1:0];
            ROT_DEC: pos_nxt = ext_dec[POS_W] ? POS_MAX : ext_dec[POS_W-1:0];
            default: pos_nxt = pos_q;
        endcase
    end

`ifdef ROT_SATURATE_EN
    logic limit_hit_q, limit_hit_d;
    logic at_limit;

    assign at_limit = (bus.rotation_direction == ROT_INC) ? (ext_inc == N_EXT) : ext_dec[POS_W];
`endif

    always_comb begin
        pos_d        = pos_q;
        step_pulse_d = 1'b0;
        step_dir_d   = step_dir_q;
`ifdef ROT_SATURATE_EN
        limit_hit_d  = 1'b0;
`endif
        // clear wins over a coincident step; the filter still consumes that event.
        if (bus.clear) begin
            pos_d = POS_INIT;
        end else if (step_req) begin
            step_dir_d = bus.rotation_direction;
`ifdef ROT_SATURATE_EN
            if (at_limit) begin
                limit_hit_d = 1'b1;
            end else begin
                pos_d        = pos_nxt;
                step_pulse_d = 1'b1;
            end
`else
            pos_d        = pos_nxt;
            step_pulse_d = 1'b1;
`endif
        end
        // Decode from the next position so led lands on the same edge as position.
        led_d = LED_ONE << pos_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q        <= POS_INIT;
            led_q        <= LED_ONE << POS_INIT;
            step_pulse_q <= 1'b0;
            step_dir_q   <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            led_q        <= led_d;
            step_pulse_q <= step_pulse_d;
            step_dir_q   <= step_dir_d;
        end
    end

`ifdef ROT_SATURATE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit_hit_q <= 1'b0;
        end else begin
            limit_hit_q <= limit_hit_d;
        end
    end

    assign bus.limit_hit = limit_hit_q;
`else
    assign bus.limit_hit = 1'b0;
`endif

    assign bus.position   = pos_q;
    assign bus.led        = led_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.step_dir   = step_dir_q;
endmodule

// File: tb/tb_rotation_position_tracker.sv
// Directed bench for rotation_position_tracker (default build, N_POS=8, MIN_LOW=4, INIT_POS=0).
// Inputs change 1 ns after each rising edge; outputs are checked at the same point.
module tb_rotation_position_tracker;
    import rot_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rotation_position_tracker_if #(.N_POS(8)) bus ();

    rotation_position_tracker #(
        .N_POS    (8),
        .MIN_LOW  (4),
        .INIT_POS (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int ev;
        int dir;
        int clr;
        int pos;
        int led;
        int pulse;
        int sdir;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int pos, input int led, input int pulse, input int sdir);
        chk({tag, ".position"},   32'(bus.position),   32'(pos));
        chk({tag, ".led"},        32'(bus.led),        32'(led));
        chk({tag, ".step_pulse"}, 32'(bus.step_pulse), 32'(pulse));
        chk({tag, ".step_dir"},   32'(bus.step_dir),   32'(sdir));
        chk({tag, ".limit_hit"},  32'(bus.limit_hit),  32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input logic dir, input logic clr);
        bus.rotation_event     = ev;
        bus.rotation_direction = dir;
        bus.clear              = clr;
    endtask

    // Four lows then a rising event; checks the step edge and that the pulse drops
    // while the event stays high. Leaves the filter in HOLD with the event high.
    task automatic do_step(input string tag, input logic dir, input int prev_pos, input int exp_pos);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, dir, 1'b0);
            tick();
        end
        chk({tag, ".pos_before"}, 32'(bus.position), 32'(prev_pos));
        drive(1'b1, dir, 1'b0);
        tick();
        check_outs({tag, ".step"}, exp_pos, 1 << exp_pos, 1, int'(dir));
        tick();
        chk({tag, ".pulse_one_cycle"}, 32'(bus.step_pulse), 32'd0);
    endtask

    initial begin
        int steps;

        drive(1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check_outs("reset", 0, 'h01, 0, 0);
        tick();
        tick();
        rst = 1'b0;

        // ev, dir, clr | position, led, step_pulse, step_dir after the edge
        for (int i = 0; i < 4; i++) tbl.push_back('{0, 0, 0, 0, 'h01, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 'h02, 1, 1});       // first increment
        for (int i = 0; i < 4; i++) tbl.push_back('{0, 1, 0, 1, 'h02, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 'h01, 1, 0});       // decrement 1 -> 0
        for (int i = 0; i < 4; i++) tbl.push_back('{0, 0, 0, 0, 'h01, 0, 0});
        tbl.push_back('{1, 0, 0, 7, 'h80, 1, 0});       // wrap 0 -> 7
        for (int i = 0; i < 3; i++) tbl.push_back('{0, 0, 0, 7, 'h80, 0, 0});
        tbl.push_back('{1, 0, 0, 7, 'h80, 0, 0});       // only 3 lows: rejected
        for (int i = 0; i < 4; i++) tbl.push_back('{0, 1, 0, 7, 'h80, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 'h01, 1, 1});       // wrap 7 -> 0

        foreach (tbl[i]) begin
            drive(1'(tbl[i].ev), 1'(tbl[i].dir), 1'(tbl[i].clr));
            tick();
            check_outs($sformatf("vec%0d", i), tbl[i].pos, tbl[i].led, tbl[i].pulse, tbl[i].sdir);
        end

        // Event held high for 20 cycles in total: only the first cycle steps.
        steps = 0;
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            tick();
            steps += int'(bus.step_pulse);
        end
        chk("held_high.extra_steps", 32'(steps), 32'd0);
        chk("held_high.position", 32'(bus.position), 32'd0);

        // Walk up to position 5.
        for (int p = 0; p < 5; p++) do_step($sformatf("walk%0d", p + 1), 1'b1, p, p + 1);

        // clear on the armed edge: position back to 0, no pulse, step_dir kept, event consumed.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b1);
        tick();
        check_outs("clear_on_step", 0, 'h01, 0, 1);
        chk("clear_on_step.state", 32'(dut.u_filter.state_q), 32'(HOLD));
        drive(1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0);
        tick();
        check_outs("clear_consumed", 0, 'h01, 0, 1);

        // Reset in the middle of HOLD with the event still high.
        do_step("pre_reset", 1'b1, 0, 1);
        rst = 1'b1;
        #1 check_outs("mid_hold_reset", 0, 'h01, 0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs($sformatf("post_reset_high%0d", i), 0, 'h01, 0, 0);
        end
        do_step("post_reset_step", 1'b1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
